// File: rtl/rhd_cmd_sequencer.sv
// RHD MOSI frame sequencer: NUM_AMP_CH CONVERT slots followed by NUM_AUX list-driven aux slots.
// Latency: cmd_valid rises 2 edges after run is seen in IDLE; each command costs LOAD + PRESENT (2 cycles min).
// Backpressure: PRESENT holds cmd_data/cmd_slot stable until cmd_ready; pointers/counters advance only on handshake.
module rhd_cmd_sequencer #(
    parameter int NUM_AMP_CH = 32,
    parameter int NUM_AUX    = 3,
    parameter int AUX_AW     = 10
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        run,
    input  logic                        dsp_settle,
    input  logic                        digout_enable,
    input  logic                        digout_override,
    input  logic                        aux_wr_en,
    input  logic [1:0]                  aux_wr_sel,
    input  logic [AUX_AW-1:0]           aux_wr_addr,
    input  logic [15:0]                 aux_wr_data,
    input  logic [NUM_AUX*AUX_AW-1:0]   aux_end_idx,
    input  logic [NUM_AUX*AUX_AW-1:0]   aux_loop_idx,
    input  logic                        cmd_ready,
    output logic                        cmd_valid,
    output logic [15:0]                 cmd_data,
    output logic [5:0]                  cmd_slot,
    output logic                        frame_start,
    output logic [31:0]                 frame_count,
    output logic                        busy
);

    localparam int         DEPTH     = 2**AUX_AW;
    localparam logic [5:0] LAST_SLOT = 6'(NUM_AMP_CH + NUM_AUX - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, PRESENT = 2'd2} state_t;

    state_t            state, state_nxt;
    logic [5:0]        slot, slot_nxt;
    logic              settle_q;
    logic              handshake;
    logic              frame_done;
    logic [15:0]       load_word;
    logic [AUX_AW-1:0] aux_ptr [NUM_AUX];
    logic [15:0]       aux_mem [NUM_AUX][DEPTH];

    assign handshake  = (state == PRESENT) && cmd_ready;
    assign frame_done = handshake && (slot == LAST_SLOT);
    assign cmd_valid  = (state == PRESENT);
    assign busy       = (state != IDLE);

    // List storage is not reset; selects beyond NUM_AUX never match and are dropped.
    always_ff @(posedge clk) begin
        for (int a = 0; a < NUM_AUX; a++) begin
            if (aux_wr_en && (int'(aux_wr_sel) == a))
                aux_mem[a][aux_wr_addr] <= aux_wr_data;
        end
    end

    // Slot 0 uses the live settle bit because settle_q is captured in that same LOAD.
    always_comb begin
        load_word = {2'b00, slot, 7'b0, (slot == 6'd0) ? dsp_settle : settle_q};
        for (int a = 0; a < NUM_AUX; a++) begin
            if (slot == 6'(NUM_AMP_CH + a)) begin
                load_word = aux_mem[a][aux_ptr[a]];
                if (digout_enable && (load_word[15:8] == 8'h83))
                    load_word[0] = digout_override;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        slot_nxt  = slot;
        case (state)
            IDLE: begin
                if (run) begin
                    slot_nxt  = 6'd0;
                    state_nxt = LOAD;
                end
            end
            LOAD: state_nxt = PRESENT;
            PRESENT: begin
                if (cmd_ready) begin
                    if (slot == LAST_SLOT) begin
                        slot_nxt  = 6'd0;
                        state_nxt = run ? LOAD : IDLE;
                    end else begin
                        slot_nxt  = slot + 6'd1;
                        state_nxt = LOAD;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            slot        <= 6'd0;
            settle_q    <= 1'b0;
            cmd_data    <= 16'd0;
            cmd_slot    <= 6'd0;
            frame_start <= 1'b0;
            frame_count <= 32'd0;
            for (int a = 0; a < NUM_AUX; a++) aux_ptr[a] <= '0;
        end else begin
            state       <= state_nxt;
            slot        <= slot_nxt;
            frame_start <= (state == LOAD) && (slot == 6'd0);
            if (state == LOAD) begin
                cmd_data <= load_word;
                cmd_slot <= slot;
                if (slot == 6'd0) settle_q <= dsp_settle;
            end
            if (state == IDLE && run) begin
                frame_count <= 32'd0;
                for (int a = 0; a < NUM_AUX; a++) aux_ptr[a] <= '0;
            end
            if (frame_done) frame_count <= frame_count + 32'd1;
            // Reaching end_a jumps to loop_a; otherwise wrap naturally at the top of the list.
            for (int a = 0; a < NUM_AUX; a++) begin
                if (handshake && (slot == 6'(NUM_AMP_CH + a))) begin
                    if (aux_ptr[a] == aux_end_idx[a*AUX_AW +: AUX_AW])
                        aux_ptr[a] <= aux_loop_idx[a*AUX_AW +: AUX_AW];
                    else
                        aux_ptr[a] <= aux_ptr[a] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rhd_cmd_sequencer.sv
// Randomized directed bench for rhd_cmd_sequencer against a list/pointer reference model.
module tb_rhd_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, run, dsp_settle, digout_enable, digout_override;
    logic        aux_wr_en;
    logic [1:0]  aux_wr_sel;
    logic [9:0]  aux_wr_addr;
    logic [15:0] aux_wr_data;
    logic [29:0] aux_end_idx, aux_loop_idx;
    logic        cmd_ready, cmd_valid, frame_start, busy;
    logic [15:0] cmd_data;
    logic [5:0]  cmd_slot;
    logic [31:0] frame_count;

    int          end_i [3];
    int          loop_i [3];
    logic [15:0] mdl_mem [3][1024];
    int          mdl_ptr [3];
    int          mdl_frames;
    int          total  = 0;
    int          passed = 0;

    assign aux_end_idx  = {10'(end_i[2]),  10'(end_i[1]),  10'(end_i[0])};
    assign aux_loop_idx = {10'(loop_i[2]), 10'(loop_i[1]), 10'(loop_i[0])};

    always #5 clk = ~clk;

    rhd_cmd_sequencer dut (
        .clk(clk), .rst_n(rst_n), .run(run), .dsp_settle(dsp_settle),
        .digout_enable(digout_enable), .digout_override(digout_override),
        .aux_wr_en(aux_wr_en), .aux_wr_sel(aux_wr_sel), .aux_wr_addr(aux_wr_addr),
        .aux_wr_data(aux_wr_data), .aux_end_idx(aux_end_idx), .aux_loop_idx(aux_loop_idx),
        .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_slot(cmd_slot),
        .frame_start(frame_start), .frame_count(frame_count), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Expected word for slot s, advancing the model list pointer as a handshake would.
    task automatic model_cmd(input int s, input bit st, output logic [15:0] w);
        if (s < 32) begin
            w = {2'b00, 6'(s), 7'b0, st};
        end else begin
            int a = s - 32;
            w = mdl_mem[a][mdl_ptr[a]];
            if (digout_enable && w[15:8] == 8'h83) w[0] = digout_override;
            mdl_ptr[a] = (mdl_ptr[a] == end_i[a]) ? loop_i[a] : (mdl_ptr[a] + 1) % 1024;
        end
    endtask

    task automatic model_restart();
        for (int a = 0; a < 3; a++) mdl_ptr[a] = 0;
        mdl_frames = 0;
    endtask

    task automatic wr(input int sel, input int addr, input logic [15:0] data);
        aux_wr_en = 1'b1; aux_wr_sel = 2'(sel); aux_wr_addr = 10'(addr); aux_wr_data = data;
        @(negedge clk);
        aux_wr_en = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (cmd_valid !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("valid_rise", cmd_valid, 1);
    endtask

    // Wait for a command, stall it, then accept it; returns at the negedge after the handshake.
    task automatic take(input int stall, output logic [5:0] s, output logic [15:0] d);
        wait_valid();
        s = cmd_slot;
        d = cmd_data;
        chk($sformatf("frame_start_s%0d", s), frame_start, (s == 6'd0));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk($sformatf("hold_valid_s%0d", s), cmd_valid, 1);
            chk($sformatf("hold_data_s%0d", s), cmd_data, d);
            chk($sformatf("hold_slot_s%0d", s), cmd_slot, s);
            chk($sformatf("hold_fstart_s%0d", s), frame_start, 0);
            chk($sformatf("hold_fcount_s%0d", s), frame_count, mdl_frames);
        end
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
    endtask

    task automatic start_run(input bit st);
        dsp_settle = st;
        run = 1'b1;
        model_restart();
        @(negedge clk);
        chk("latency_edge1_valid", cmd_valid, 0);
        chk("latency_edge1_busy", busy, 1);
        @(negedge clk);
        chk("latency_edge2_valid", cmd_valid, 1);
    endtask

    task automatic run_frame(input bit st, input int drop_at, input int rst_at,
                             input int wr_at, input int wr_sel, input int long_stall_at);
        logic [5:0]  s;
        logic [15:0] d, e, wdat;
        int          stall, waddr;
        waddr = 0;
        wdat  = 16'h0;
        for (int k = 0; k < 35; k++) begin
            dsp_settle = (k == 0) ? st : 1'($urandom);
            if (k == drop_at) run = 1'b0;
            if (k == wr_at) begin
                waddr = (wr_sel < 3) ? mdl_ptr[wr_sel] : 0;
                wdat  = 16'($urandom) & 16'h7FFF;
                wr(wr_sel, waddr, wdat);
            end
            if (k == rst_at) begin
                wait_valid();
                rst_n = 1'b0;
                run   = 1'b0;
                #1;
                chk("rst_valid", cmd_valid, 0);
                chk("rst_fcount", frame_count, 0);
                chk("rst_busy", busy, 0);
                chk("rst_data", cmd_data, 0);
                chk("rst_slot", cmd_slot, 0);
                @(negedge clk);
                rst_n = 1'b1;
                model_restart();
                return;
            end
            stall = (k == long_stall_at) ? 5 :
                    (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
            take(stall, s, d);
            model_cmd(k, st, e);
            chk($sformatf("slot_k%0d", k), s, k);
            chk($sformatf("data_k%0d", k), d, e);
            // A write to the entry being read in the same cycle only shows up on later reads.
            if (k == wr_at && wr_sel < 3) mdl_mem[wr_sel][waddr] = wdat;
        end
        mdl_frames++;
        chk("frame_count", frame_count, mdl_frames);
        chk("busy_after_frame", busy, run);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] w;
        rst_n = 1'b0; run = 1'b0; dsp_settle = 1'b0; cmd_ready = 1'b0;
        digout_enable = 1'b0; digout_override = 1'b0;
        aux_wr_en = 1'b0; aux_wr_sel = 2'd0; aux_wr_addr = 10'd0; aux_wr_data = 16'd0;
        end_i  = '{3, 1, 2};
        loop_i = '{1, 0, 1021};
        model_restart();
        repeat (2) @(negedge clk);
        chk("reset_valid", cmd_valid, 0);
        chk("reset_data", cmd_data, 0);
        chk("reset_slot", cmd_slot, 0);
        chk("reset_fstart", frame_start, 0);
        chk("reset_fcount", frame_count, 0);
        chk("reset_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // List0: A,B,C,D looping 3->1; list1: 8300/8200; list2 wraps 2->1021..1023->0.
        for (int i = 0; i < 4; i++) begin
            w = 16'($urandom) & 16'h7FFF;
            wr(0, i, w);
            mdl_mem[0][i] = w;
        end
        wr(1, 0, 16'h8300); mdl_mem[1][0] = 16'h8300;
        wr(1, 1, 16'h8200); mdl_mem[1][1] = 16'h8200;
        for (int i = 0; i < 6; i++) begin
            int addr = (i < 3) ? i : 1018 + i;
            w = (addr == 1022) ? 16'h83A4 : (16'($urandom) & 16'h7FFF);
            wr(2, addr, w);
            mdl_mem[2][addr] = w;
        end

        digout_enable = 1'b1; digout_override = 1'b1;
        start_run(1'b1);
        run_frame(1'b1, -1, -1, -1, 0, -1);

        for (int f = 2; f <= 6; f++) begin
            digout_enable   = 1'(f % 2);
            digout_override = 1'($urandom);
            run_frame((f == 3) ? 1'b0 : 1'($urandom), -1, -1,
                      (f == 4) ? 32 : ((f == 5) ? 20 : -1),
                      (f == 4) ? 0 : 3,
                      (f == 3) ? 10 : -1);
        end

        run_frame(1'b1, 3, -1, -1, 0, -1);
        repeat (3) @(negedge clk);
        chk("idle_valid", cmd_valid, 0);
        chk("idle_busy", busy, 0);
        chk("idle_fcount", frame_count, 7);

        start_run(1'b0);
        run_frame(1'b0, -1, -1, -1, 0, -1);
        run_frame(1'b1, -1, 33, -1, 0, -1);
        repeat (2) @(negedge clk);
        chk("post_rst_idle", busy, 0);

        start_run(1'b1);
        run_frame(1'b1, 0, -1, -1, 0, -1);
        chk("final_fcount", frame_count, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
